// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register family:
// operation encodings and the shift-counter width derivation.
package univ_shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  // Counter must be at least one bit wide even for the smallest register.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/univ_shift_reg_chk.sv
// Simulation checks for univ_shift_reg: the operation select must be known
// whenever the register is enabled and out of reset.
module univ_shift_reg_chk (
  input logic       clk,
  input logic       reset,
  input logic       en,
  input logic [2:0] mode
);

  mode_known_a: assert property (@(posedge clk) (reset && en) |-> !$isunknown(mode))
    else $error("univ_shift_reg: mode is X while enabled");

endmodule

// File: rtl/univ_shift_reg_shift_frame_cnt.sv
// Frame counter for serial blocks: counts steps modulo WIDTH and emits a
// registered one-cycle done pulse when the WIDTH-th step completes.
module shift_frame_cnt
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next-state: clear beats step, so a load on the wrap cycle yields no done.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clear_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (step_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = {CNT_W{1'b0}};
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= {CNT_W{1'b0}};
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: load, logical/arithmetic shifts and
// rotates, registered serial-out and a self-timed frame counter.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             step_s, clear_s;

  // Decode which operations advance or restart the frame counter.
  always_comb begin
    step_s  = 1'b0;
    clear_s = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_LOAD: clear_s = 1'b1;
        MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: step_s = 1'b1;
        default: begin
          step_s  = 1'b0;
          clear_s = 1'b0;
        end
      endcase
    end else begin
      step_s  = 1'b0;
      clear_s = 1'b0;
    end
  end

  // Data path next-state; HOLD and the reserved code both keep state.
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    if (en) begin
      case (mode_e'(mode))
        MODE_LOAD: begin
          q_d    = d;
          sout_d = 1'b0;
        end
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
        end
        MODE_SHR: begin
          q_d    = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          sout_d = q_q[WIDTH-1];
        end
        MODE_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        MODE_ASR: begin
          q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        default: begin
          q_d    = q_q;
          sout_d = sout_q;
        end
      endcase
    end else begin
      q_d    = q_q;
      sout_d = sout_q;
    end
  end

  // Data path registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= RESET_VAL;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  shift_frame_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .clk_i   (clk),
    .rst_ni  (reset),
    .step_i  (step_s),
    .clear_i (clear_s),
    .cnt_o   (cnt),
    .done_o  (done)
  );

  univ_shift_reg_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode)
  );

  assign q    = q_q;
  assign sout = sout_q;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, successor to the team's fixed 4-bit load/shift-left/shift-right register.
- Generalised to WIDTH bits.
- Adds rotate, arithmetic shift, clock enable, and a registered serial-out bit.
- Adds a shift counter with a one-cycle done pulse, so the block can act as a self-timed serialiser/deserialiser in datapath and UART-style front ends.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
CNT_W, $clog2(WIDTH), width of the shift counter; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
en  input  1  clock enable; when 0, all state holds.
mode  input  3  operation select (encodings under Behaviour).
d  input  WIDTH  parallel load data.
sin  input  1  serial input for logical shifts.
q  output  WIDTH  register contents.
sout  output  1  registered copy of the last bit shifted or rotated out.
cnt  output  CNT_W  shift operations since last load or reset, modulo WIDTH.
done  output  1  one-cycle pulse when the WIDTH-th shift since the last load completes.

Behaviour:
- All state updates on the rising edge of clk. No combinational path from any input to any output.
- Reset priority:
  - reset=0 overrides en and mode.
  - Result: q=RESET_VAL, sout=0, cnt=0, done=0.
- en=0: q, sout and cnt hold; done=0.
- en=1, mode encodings:
  - 0 HOLD: q, sout and cnt hold; done=0.
  - 1 LOAD: q<=d; cnt<=0; sout<=0; done=0.
  - 2 SHL: q<={q[W-2:0],sin}; sout<=q[W-1].
  - 3 SHR: q<={sin,q[W-1:1]}; sout<=q[0].
  - 4 ROL: q<={q[W-2:0],q[W-1]}; sout<=q[W-1]; sin ignored.
  - 5 ROR: q<={q[0],q[W-1:1]}; sout<=q[0]; sin ignored.
  - 6 ASR: q<={q[W-1],q[W-1:1]}; sout<=q[0]; sin ignored.
  - 7 reserved: behaves exactly as HOLD.
- Shift ops (modes 2-6), en=1:
  - If cnt==WIDTH-1: cnt<=0 and done<=1.
  - Otherwise: cnt<=cnt+1 and done<=0.
- done is registered, asserted for exactly one cycle per WIDTH shifts. It does not re-assert while idle.
- sout reflects the bit removed by the previous shift, available the cycle after the shift.
- All outputs use non-blocking assignment.
- Boundary conditions:
  - LOAD in the same cycle cnt would wrap: LOAD wins; cnt=0, done=0.
  - en dropped mid-frame: cnt freezes; it resumes counting when en returns.
  - Reset mid-frame: cnt clears and any pending done is suppressed.
  - Mixed shift modes within a frame all count toward the same cnt.
- An X on mode while en=1 and reset=1 is an assertion failure in simulation.

Decomposition:
- Shared package: mode encodings MODE_HOLD..MODE_ASR and MODE_RSVD as 3-bit localparams/enum, plus the CNT_W derivation helper.
- One natural sub-module: shift_frame_cnt. It takes WIDTH, a step input and a clear input, and produces cnt and done. It is reused by later serial blocks.
- The data path stays inline.

Test Plan:
1. WIDTH=4, RESET_VAL=4'hA. Hold reset=0 for 2 cycles with en=1, mode=SHL, then release -> q=4'hA, sout=0, cnt=0, done=0 throughout reset.
2. LOAD d=4'b1011, then 4×SHL with sin=0 -> q: 0110, 1100, 1000, 0000; sout: 1, 0, 1, 1; cnt: 1, 2, 3, 0; done=1 only on the cycle after the 4th shift.
3. LOAD 4'b1001, then ROR ×2 -> q: 1100, 0110; sout: 1, 0. Then ASR on 4'b1000 (after LOAD) -> q=1100, sout=0.
4. LOAD 4'h5, 2×SHR with sin=1, en=0 for 3 cycles, then 2×SHR -> cnt holds at 2 while en=0; done pulses after the 4th shift only; final q=4'hF.
5. After 3 shifts, apply LOAD in the cycle where a 4th shift would wrap -> cnt=0, done stays 0, q=d.
6. Apply mode=7 and mode=HOLD with en=1 on q=4'h3 -> q, sout and cnt unchanged; done=0.
